// File: rtl/rr_arbiter8_pkg.sv
// arb_pkg: shared widths, FSM state type and the rotate helper for rr_arbiter8.
package arb_pkg;
    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {IDLE, BUSY} state_t;

    // Index 0 is the leftmost bit, so a left shift moves requester s to position 0.
    function automatic logic [0:N_REQ-1] rotl(input logic [0:N_REQ-1] v, input logic [IDX_W-1:0] s);
        return (v << s) | (v >> (4'(N_REQ) - {1'b0, s}));
    endfunction
endpackage

// File: rtl/rr_arbiter8_if.sv
// rr_arbiter8_if: requester-side handshake and grant outputs of the arbiter.
interface rr_arbiter8_if;
    import arb_pkg::*;
    logic               enable;
    logic [0:N_REQ-1]   req;
    logic               done;
    logic               gnt_valid;
    logic [0:IDX_W-1]   gnt_idx;
    logic [0:N_REQ-1]   gnt_onehot;
    logic               timeout;

    modport master (output enable, req, done, input gnt_valid, gnt_idx, gnt_onehot, timeout);
    modport slave  (input enable, req, done, output gnt_valid, gnt_idx, gnt_onehot, timeout);
endinterface

// File: rtl/rr_arbiter8_pri_enc8.sv
// pri_enc8: first-one encoder over [0:7]; anything other than a clean 1 counts as 0.
module pri_enc8
    import arb_pkg::*;
(
    input  logic [0:N_REQ-1] vec_i,
    output logic [0:IDX_W-1] idx_o,
    output logic             found_o
);
    always_comb begin
        idx_o = '0;
        found_o = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (vec_i[i] === 1'b1) begin
                idx_o = IDX_W'(i);
                found_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-way round-robin arbiter with done/drop/hold-limit release.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 15
)(
    input  logic           clk,
    input  logic           rst,
    rr_arbiter8_if.slave   bus
);
    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [3:0]        hold_q, hold_d;
    logic [0:IDX_W-1]  idx_q, idx_d;
    logic [0:N_REQ-1]  oh_q, oh_d;
    logic              to_q, to_d;
    logic [0:N_REQ-1]  rot_req;
    logic [0:IDX_W-1]  enc_idx, nxt_idx;
    logic              found, owner_req, hit_limit;

    assign rot_req = rotl(bus.req, ptr_q);

    pri_enc8 u_enc (
        .vec_i   (rot_req),
        .idx_o   (enc_idx),
        .found_o (found)
    );

    assign nxt_idx   = enc_idx + ptr_q;
    assign owner_req = bus.req[idx_q] === 1'b1;
    assign hit_limit = hold_q == 4'(MAX_HOLD - 1);

    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        hold_d = hold_q;
        idx_d = idx_q;
        oh_d = oh_q;
        to_d = 1'b0;
        if (state_q == IDLE) begin
            if (bus.enable && found) begin
                state_d = BUSY;
                idx_d = nxt_idx;
                oh_d = 8'b1000_0000 >> nxt_idx;
                hold_d = '0;
            end
        end else if (bus.done || !owner_req || hit_limit) begin
            state_d = IDLE;
            ptr_d = idx_q + 3'd1;
            oh_d = '0;
            // Timeout only when the hold limit alone forced the release.
            to_d = !bus.done && owner_req;
        end else begin
            hold_d = hold_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q <= '0;
            hold_q <= '0;
            idx_q <= '0;
            oh_q <= '0;
            to_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            hold_q <= hold_d;
            idx_q <= idx_d;
            oh_q <= oh_d;
            to_q <= to_d;
        end
    end

    assign bus.gnt_valid  = state_q == BUSY;
    assign bus.gnt_idx    = idx_q;
    assign bus.gnt_onehot = oh_q;
    assign bus.timeout    = to_q;
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: scenario tasks plus a grant-order scoreboard for rr_arbiter8 (MAX_HOLD=4).
module tb_rr_arbiter8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   exp_q[$];
    logic prev_v = 1'b0;

    rr_arbiter8_if bus();

    rr_arbiter8 #(.MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every new grant must match the next expected owner in issue order.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            #1;
            if (bus.gnt_valid && !prev_v) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got grant idx=%0d, required none", bus.gnt_idx);
                end else begin
                    logic [2:0] e;
                    logic [0:7] eoh;
                    e = 3'(exp_q.pop_front());
                    eoh = 8'b1000_0000 >> e;
                    if (bus.gnt_idx !== e || bus.gnt_onehot !== eoh) begin
                        errors++;
                        $display("FAIL sb_grant: got idx=%0d oh=%b, required idx=%0d oh=%b",
                                 bus.gnt_idx, bus.gnt_onehot, e, eoh);
                    end
                end
            end
            checks++;
            if (bus.timeout && bus.gnt_valid) begin
                errors++;
                $display("FAIL to_overlap: got timeout=1 with gnt_valid=1, required not both");
            end
            prev_v = bus.gnt_valid;
        end
    end

    task automatic test_reset();
        bus.enable = 1'b0;
        bus.req = '0;
        bus.done = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.gnt_valid !== 1'b0 || bus.gnt_idx !== 3'b000 || bus.gnt_onehot !== 8'b0 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset: got v=%b idx=%b oh=%b to=%b, required all zero",
                     bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot, bus.timeout);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fairness();
        bus.enable = 1'b1;
        bus.req = 8'hFF;
        bus.done = 1'b1;
        for (int k = 0; k < 9; k++) begin
            exp_q.push_back(k % 8);
            tick();
            checks++;
            if (bus.gnt_valid !== 1'b1 || bus.gnt_idx !== 3'(k % 8) || bus.timeout !== 1'b0) begin
                errors++;
                $display("FAIL fair_grant%0d: got v=%b idx=%0d to=%b, required v=1 idx=%0d to=0",
                         k, bus.gnt_valid, bus.gnt_idx, bus.timeout, k % 8);
            end
            tick();
            checks++;
            if (bus.gnt_valid !== 1'b0 || bus.timeout !== 1'b0) begin
                errors++;
                $display("FAIL fair_idle%0d: got v=%b to=%b, required v=0 to=0", k, bus.gnt_valid, bus.timeout);
            end
        end
        bus.req = '0;
        bus.done = 1'b0;
        tick();
    endtask

    task automatic test_single();
        bus.req = 8'b0000_0100;
        exp_q.push_back(5);
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (bus.gnt_valid !== 1'b1 || bus.gnt_idx !== 3'b101 || bus.gnt_onehot !== 8'b0000_0100) begin
                errors++;
                $display("FAIL single_hold%0d: got v=%b idx=%b oh=%b, required v=1 idx=101 oh=00000100",
                         c, bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot);
            end
        end
        bus.done = 1'b1;
        tick();
        checks++;
        if (bus.gnt_valid !== 1'b0 || bus.gnt_onehot !== 8'b0 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL single_release: got v=%b oh=%b to=%b, required 0/0/0",
                     bus.gnt_valid, bus.gnt_onehot, bus.timeout);
        end
        bus.done = 1'b0;
        bus.req = 8'hFF;
        exp_q.push_back(6);
        tick();
        checks++;
        if (bus.gnt_valid !== 1'b1 || bus.gnt_idx !== 3'd6) begin
            errors++;
            $display("FAIL single_next: got v=%b idx=%0d, required v=1 idx=6", bus.gnt_valid, bus.gnt_idx);
        end
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        bus.req = '0;
        tick();
    endtask

    task automatic test_reset_mid_busy();
        bus.req = 8'b0001_0000;
        exp_q.push_back(3);
        tick();
        checks++;
        if (bus.gnt_valid !== 1'b1 || bus.gnt_idx !== 3'd3) begin
            errors++;
            $display("FAIL rmb_grant: got v=%b idx=%0d, required v=1 idx=3", bus.gnt_valid, bus.gnt_idx);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.gnt_valid !== 1'b0 || bus.gnt_idx !== 3'b000 || bus.gnt_onehot !== 8'b0 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL rmb_async: got v=%b idx=%b oh=%b to=%b, required all zero",
                     bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot, bus.timeout);
        end
        rst = 1'b0;
        bus.req = 8'b1001_0000;
        exp_q.push_back(0);
        tick();
        checks++;
        if (bus.gnt_valid !== 1'b1 || bus.gnt_idx !== 3'd0) begin
            errors++;
            $display("FAIL rmb_ptr0: got v=%b idx=%0d, required v=1 idx=0", bus.gnt_valid, bus.gnt_idx);
        end
        bus.req = '0;
        tick();
        tick();
    endtask

    task automatic test_hold_limit();
        bus.req = 8'b0010_1000;
        exp_q.push_back(2);
        exp_q.push_back(4);
        tick();
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (bus.gnt_valid !== 1'b1 || bus.gnt_idx !== 3'd2 || bus.timeout !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d: got v=%b idx=%0d to=%b, required v=1 idx=2 to=0",
                         c, bus.gnt_valid, bus.gnt_idx, bus.timeout);
            end
            tick();
        end
        checks++;
        if (bus.gnt_valid !== 1'b0 || bus.timeout !== 1'b1) begin
            errors++;
            $display("FAIL hold_timeout: got v=%b to=%b, required v=0 to=1", bus.gnt_valid, bus.timeout);
        end
        tick();
        checks++;
        if (bus.gnt_valid !== 1'b1 || bus.gnt_idx !== 3'd4 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL hold_next: got v=%b idx=%0d to=%b, required v=1 idx=4 to=0",
                     bus.gnt_valid, bus.gnt_idx, bus.timeout);
        end
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        bus.req = '0;
        tick();
    endtask

    task automatic test_done_vs_limit();
        bus.req = 8'b0100_0000;
        exp_q.push_back(1);
        tick();
        tick();
        tick();
        tick();
        bus.done = 1'b1;
        tick();
        checks++;
        if (bus.gnt_valid !== 1'b0 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL simul_release: got v=%b to=%b, required v=0 to=0", bus.gnt_valid, bus.timeout);
        end
        bus.done = 1'b0;
        bus.req = '0;
        tick();
        checks++;
        if (bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL simul_after: got to=%b, required to=0", bus.timeout);
        end
    endtask

    task automatic test_gating();
        bus.enable = 1'b0;
        bus.req = 8'hFF;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (bus.gnt_valid !== 1'b0) begin
                errors++;
                $display("FAIL gate_off%0d: got v=%b, required v=0", c, bus.gnt_valid);
            end
        end
        bus.enable = 1'b1;
        exp_q.push_back(2);
        tick();
        bus.enable = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (bus.gnt_valid !== 1'b1 || bus.gnt_idx !== 3'd2) begin
                errors++;
                $display("FAIL gate_keep%0d: got v=%b idx=%0d, required v=1 idx=2", c, bus.gnt_valid, bus.gnt_idx);
            end
        end
        bus.req = 8'b1101_1111;
        tick();
        checks++;
        if (bus.gnt_valid !== 1'b0 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL gate_drop: got v=%b to=%b, required v=0 to=0", bus.gnt_valid, bus.timeout);
        end
        tick();
        checks++;
        if (bus.gnt_valid !== 1'b0 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL gate_after: got v=%b to=%b, required v=0 to=0", bus.gnt_valid, bus.timeout);
        end
        bus.req = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_single();
        test_reset_mid_busy();
        test_hold_limit();
        test_done_vs_limit();
        test_gating();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d grants outstanding, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Round-robin arbiter that shares one downstream resource among eight requesters, built around the team's 8-to-3 priority-encoding datapath. Each cycle in IDLE it encodes the request vector, starting at a rotating pointer, into a registered grant index and one-hot grant. It holds the grant until the owner signals completion, drops its request, or exceeds a hold limit. It sits between the requester array and any shared bus or port that needs a single 3-bit owner index.

## Interface
- MAX_HOLD, 15: maximum cycles one grant may be held (legal range 1..15; hold counter is 4 bits)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- enable  input  1  permits new grants; does not affect a grant already issued
- req  input  [0:7]  request vector; req[i] is requester i (index 0 = leftmost bit)
- done  input  1  current owner finished; sampled only while a grant is active
- gnt_valid  output  1  a grant is active
- gnt_idx  output  [0:2]  binary index of owner, MSB first (requester 5 = 3'b101)
- gnt_onehot  output  [0:7]  gnt_onehot[i]=1 for the owner, all zero when gnt_valid=0
- timeout  output  1  one-cycle pulse: previous grant was revoked by the hold limit

## Operation
- States: IDLE, BUSY. Two-state FSM with registered outputs.
- Internal state: ptr (3 bits), hold_cnt (4 bits).
- IDLE arbitration:
  - If enable=1 and any req bit is set, select the first set bit searching ptr, ptr+1, …, 7, 0, …, ptr-1 (mod 8).
  - Load gnt_idx, set gnt_onehot and gnt_valid, clear hold_cnt, then go to BUSY.
  - Otherwise stay in IDLE with gnt_valid=0 and gnt_onehot=0; gnt_idx holds its last value.
- BUSY release conditions, evaluated each cycle in priority order:
  1. done=1: release, no timeout.
  2. req[gnt_idx]=0: release, no timeout.
  3. hold_cnt==MAX_HOLD-1: release, timeout=1 in the following cycle.
  4. Else hold_cnt+1 and stay in BUSY.
- On any release:
  - ptr ← gnt_idx+1 mod 8 (7 wraps to 0).
  - gnt_valid and gnt_onehot go to 0; state returns to IDLE.
- enable=0 during BUSY has no effect on the current grant.
- Requests arriving during BUSY wait for the next IDLE cycle.
- X or Z on req must never propagate to gnt_idx. The encoder treats any non-1 value as 0.

## Timing
- Reset (async, immediate, including mid-BUSY): state=IDLE, ptr=0, hold_cnt=0, gnt_valid=0, gnt_idx=3'b000, gnt_onehot=8'b0, timeout=0.
- Grant latency: a request present at IDLE edge N produces gnt_valid=1 after edge N (one cycle).
- Release latency:
  - done=1 sampled at edge M drops gnt_valid after edge M.
  - Because arbitration runs only in IDLE, there is exactly one idle cycle between consecutive grants.
  - Maximum throughput is one grant per two cycles.
- Hold limit: with no done and req held, gnt_valid stays high for exactly MAX_HOLD cycles. timeout pulses in the first IDLE cycle after.
- Simultaneous done and hold limit: done wins; timeout stays 0.
- timeout is never high at the same time as gnt_valid.
- Starvation bound: a continuously asserted request is granted within 8 grant cycles.

## Structure
- arb_pkg holds:
  - N_REQ=8 and IDX_W=3
  - state enum {IDLE, BUSY}
  - a rotate-left function over [0:7]
- One sub-module, pri_enc8: a combinational first-one encoder over [0:7] with outputs idx[0:2] and found.
- Rotated arbitration:
  - Rotate req left by ptr and pass it to pri_enc8.
  - gnt_idx_next = idx+ptr mod 8.
- Top module: FSM, ptr, hold_cnt, output registers.

## Test plan
- Reset mid-BUSY: grant held on requester 3, assert rst asynchronously → all outputs zero without waiting for clk; ptr=0, so the next grant with req=8'b1001_0000 goes to 0.
- Single request: req[5]=1, done at 3rd BUSY cycle → gnt_idx=3'b101 and gnt_onehot=8'b0000_0100 for 3 cycles, then one idle cycle; next grant with all req high goes to 6.
- Fairness: all req=1, done asserted in every BUSY cycle → grant order 0,1,2,3,4,5,6,7,0 with one idle cycle between grants; timeout is never set.
- Hold limit with MAX_HOLD=4: req[2] and req[4] held high, done=0 → requester 2 granted for exactly 4 cycles, timeout pulse, then requester 4 granted.
- Simultaneous done and hold limit with MAX_HOLD=4: done=1 in the 4th BUSY cycle → release with timeout=0.
- Gating: with enable=0 and req=8'hFF, no grant is issued. Dropping enable during BUSY keeps the current grant. Dropping req[gnt_idx] during BUSY releases the grant with no timeout.
